// File: rtl/div_tick_ctrl.sv
// Four-channel programmable divider with glitch-free run-time divisor retuning.
// Optional macro DIV_TICK_STROBE_EN builds the per-channel rising-edge tick strobe.
module div_tick_ctrl #(
    parameter logic [31:0] DIV0_RST = 32'd24999999,
    parameter logic [31:0] DIV1_RST = 32'd2499999,
    parameter logic [31:0] DIV2_RST = 32'd249999,
    parameter logic [31:0] DIV3_RST = 32'd24999
) (
    input  logic        CP,
    input  logic        CR,
    input  logic [3:0]  ch_en,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_ch,
    input  logic [31:0] cfg_div,
    output logic        cfg_done,
    output logic        busy,
    output logic [3:0]  sq,
    output logic [3:0]  tick
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic [31:0] cnt [4];
    logic [31:0] div [4];
    logic [1:0]  lat_ch;
    logic [31:0] lat_div;
    logic [3:0]  at_tc;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        at_tc = '0;
        for (int n = 0; n < 4; n++) begin
            at_tc[n] = ch_en[n] && (cnt[n] == div[n]);
        end
    end

    // NOTE: the counter/divisor arrays are small register banks and must reset,
    // unlike RAM-style storage; sequential state uses non-blocking assignments only.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            for (int n = 0; n < 4; n++) begin
                cnt[n] <= '0;
            end
            sq <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (!ch_en[n]) begin
                    cnt[n] <= '0;
                    sq[n]  <= 1'b0;
                end else if (at_tc[n]) begin
                    cnt[n] <= '0;
                    sq[n]  <= ~sq[n];
                end else begin
                    cnt[n] <= cnt[n] + 32'd1;
                end
            end
        end
    end

    // The new divisor lands on the terminal-count edge, so the current half-period
    // finishes with the old value and the next one starts from cnt=0.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state     <= IDLE;
            lat_ch    <= '0;
            lat_div   <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            cfg_done  <= 1'b0;
            div[0]    <= DIV0_RST;
            div[1]    <= DIV1_RST;
            div[2]    <= DIV2_RST;
            div[3]    <= DIV3_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        lat_ch    <= cfg_ch;
                        lat_div   <= cfg_div;
                        state     <= WAIT;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    if (at_tc[lat_ch] || !ch_en[lat_ch]) begin
                        div[lat_ch] <= lat_div;
                        state       <= DONE;
                        cfg_done    <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cfg_done  <= 1'b0;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cfg_done  <= 1'b0;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIV_TICK_STROBE_EN
    // Strobe coincides with the cycle in which sq rises.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            tick <= '0;
        end else begin
            tick <= at_tc & ~sq;
        end
    end
`else
    assign tick = 4'b0000;
`endif

endmodule

// File: tb/tb_div_tick_ctrl.sv
// Randomized self-checking bench for div_tick_ctrl against a half-period countdown model.
module tb_div_tick_ctrl;

    localparam int unsigned D0 = 3;
    localparam int unsigned D1 = 1;
    localparam int unsigned D2 = 0;
    localparam int unsigned D3 = 9;

    logic        CP = 1'b0;
    logic        CR;
    logic [3:0]  ch_en;
    logic        cfg_valid;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_div;
    logic        cfg_ready;
    logic        cfg_done;
    logic        busy;
    logic [3:0]  sq;
    logic [3:0]  tick;

    div_tick_ctrl #(
        .DIV0_RST(D0), .DIV1_RST(D1), .DIV2_RST(D2), .DIV3_RST(D3)
    ) dut (
        .CP(CP), .CR(CR), .ch_en(ch_en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_done(cfg_done), .busy(busy),
        .sq(sq), .tick(tick)
    );

    always #5 CP = ~CP;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: each channel counts down the edges left in its half-period (div+1 edges).
    int unsigned m_div [4];
    int unsigned m_rem [4];
    logic [3:0]  m_sq, m_tick;
    int          m_st;        // 0 idle, 1 waiting for terminal count, 2 done
    int          m_ch;
    int unsigned m_val;
    bit          m_acc;

    int          cyc = 0;
    logic [3:0]  prev_sq;
    int          rises [4][$];
    int          tog0 [$];

    function automatic void m_reset();
        m_div = '{D0, D1, D2, D3};
        for (int n = 0; n < 4; n++) m_rem[n] = m_div[n] + 1;
        m_sq  = '0;
        m_tick = '0;
        m_st  = 0;
        m_acc = 1'b0;
    endfunction

    function automatic void m_step();
        logic [3:0] tc;
        m_acc = 1'b0;
        for (int n = 0; n < 4; n++) tc[n] = ch_en[n] && (m_rem[n] == 1);
        case (m_st)
            0: if (cfg_valid) begin
                   m_ch = int'(cfg_ch); m_val = cfg_div; m_st = 1; m_acc = 1'b1;
               end
            1: if (tc[m_ch] || !ch_en[m_ch]) begin
                   m_div[m_ch] = m_val; m_st = 2;
               end
            default: m_st = 0;
        endcase
        for (int n = 0; n < 4; n++) begin
            m_tick[n] = 1'b0;
            if (!ch_en[n]) begin
                m_sq[n] = 1'b0; m_rem[n] = m_div[n] + 1;
            end else if (tc[n]) begin
                m_tick[n] = !m_sq[n]; m_sq[n] = !m_sq[n]; m_rem[n] = m_div[n] + 1;
            end else begin
                m_rem[n] = m_rem[n] - 1;
            end
        end
    endfunction

    task automatic compare();
        logic [3:0] exp_tick;
`ifdef DIV_TICK_STROBE_EN
        exp_tick = m_tick;
`else
        exp_tick = 4'b0000;
`endif
        check("sq", sq, m_sq);
        check("tick", tick, exp_tick);
        check("cfg_ready", cfg_ready, m_st == 0);
        check("busy", busy, m_st != 0);
        check("cfg_done", cfg_done, m_st == 2);
    endtask

    task automatic cycle();
        prev_sq = sq;
        @(posedge CP);
        if (CR) m_reset(); else m_step();
        #1;
        cyc++;
        for (int n = 0; n < 4; n++) if (sq[n] && !prev_sq[n]) rises[n].push_back(cyc);
        if (sq[0] != prev_sq[0]) tog0.push_back(cyc);
        compare();
    endtask

    initial begin
        int done_cyc, acc_cyc, en_cyc, k0, low;
        bit got;
        CR = 1'b1; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        m_reset();
        #2;
        compare();
        cycle();
        CR = 1'b0;

        // Reset divisors 3/1/0/9 give periods 8/4/2/20.
        ch_en = 4'hF;
        for (int n = 0; n < 4; n++) rises[n].delete();
        for (int k = 0; k < 45; k++) cycle();
        begin
            int exp_per [4] = '{8, 4, 2, 20};
            for (int n = 0; n < 4; n++) begin
                if (rises[n].size() < 2) check($sformatf("rises%0d", n), rises[n].size(), 2);
                else check($sformatf("period%0d", n), rises[n][$] - rises[n][$-1], exp_per[n]);
            end
        end

        // Retune ch0 from 3 to 7 while its counter sits at 1.
        for (int k = 0; k < 20 && m_rem[0] != 3; k++) cycle();
        k0 = tog0.size() - 1;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd7;
        cycle();
        cfg_valid = 1'b0;
        done_cyc = -1;
        for (int k = 0; k < 25; k++) begin
            cycle();
            if (cfg_done && done_cyc < 0) done_cyc = cyc;
        end
        if (k0 < 0 || tog0.size() < k0 + 4) check("tog0_count", tog0.size(), k0 + 4);
        else begin
            check("half_old", tog0[k0+1] - tog0[k0], 4);
            check("half_new1", tog0[k0+2] - tog0[k0+1], 8);
            check("half_new2", tog0[k0+3] - tog0[k0+2], 8);
            // cfg_done is high in the cycle that follows the switch edge.
            check("done_at_switch", done_cyc, tog0[k0+1]);
        end

        // Request to disabled ch2 completes in minimum time.
        ch_en[2] = 1'b0;
        cycle();
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 32'd5;
        cycle();
        acc_cyc = cyc;
        cfg_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle();
            if (cfg_done) begin got = 1'b1; done_cyc = cyc; end
        end
        check("dis_done_seen", got, 1'b1);
        check("dis_latency", done_cyc - acc_cyc + 1, 2);
        rises[2].delete();
        ch_en[2] = 1'b1;
        cycle();
        en_cyc = cyc;
        for (int k = 0; k < 12 && rises[2].size() == 0; k++) cycle();
        if (rises[2].size() == 0) check("ch2_rise_seen", 0, 1);
        else check("ch2_first_rise", rises[2][0] - en_cyc + 1, 6);

        // Held second request is taken only after the first completes.
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd2;
        cycle();
        cfg_ch = 2'd3; cfg_div = 32'd4;
        low = (cfg_ready == 1'b0) ? 1 : 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle();
            if (m_acc) got = 1'b1;
            else if (!cfg_ready) low++;
        end
        cfg_valid = 1'b0;
        check("second_accepted", got, 1'b1);
        check("ready_low_ge2", low >= 2, 1'b1);
        for (int k = 0; k < 20 && m_st != 0; k++) cycle();

        // Reset while waiting discards the request.
        for (int k = 0; k < 20 && m_rem[0] <= 4; k++) cycle();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd2;
        cycle();
        cfg_valid = 1'b0;
        cycle();
        check("busy_before_cr", busy, 1'b1);
        CR = 1'b1;
        #1;
        m_reset();
        check("cr_ready", cfg_ready, 1'b1);
        check("cr_busy", busy, 1'b0);
        check("cr_sq", sq, 4'h0);
        check("cr_done", cfg_done, 1'b0);
        cycle();
        CR = 1'b0;
        for (int k = 0; k < 30; k++) cycle();

        // Dropping ch_en[1] clears its output on the next edge.
        ch_en[1] = 1'b0;
        cycle();
        check("drop_sq1", sq[1], 1'b0);
        check("drop_tick1", tick[1], 1'b0);
        for (int k = 0; k < 5; k++) cycle();

        // Random enables and configuration traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) ch_en[$urandom_range(3)] ^= 1'b1;
            if (!cfg_valid && $urandom_range(3) == 0) begin
                cfg_valid = 1'b1;
                cfg_ch    = 2'($urandom_range(3));
                cfg_div   = 32'($urandom_range(9));
            end
            cycle();
            if (m_acc) cfg_valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
